// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage program counter controller.
// Owns PCF, sequences PC+4 advances, applies Execute-stage redirects
// (immediately when the instruction memory is ready, otherwise through a
// one-entry pending register), and raises the pipeline flush strobes.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallF,
    input  logic        ImemReady,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        ImemReq,
    output logic        FlushD,
    output logic        FlushE,
    output logic        RedirPending,
    output logic        MisalignF
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] pcf_r;
    logic [31:0] pend_tgt_r;
    logic        pend_r;
    logic        misalign_r;
    logic        imem_req_r;

    logic [31:0] aligned_tgt_s;
    logic [31:0] redir_tgt_s;
    logic        have_redir_s;
    logic        adv_s;
    logic [31:0] pcplus4_s;

    // Instruction addresses are word aligned; low two bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Redirect selection: a live Execute redirect beats the stored one.
    always_comb begin
        aligned_tgt_s = align_word(PCTargetE);
        redir_tgt_s   = pend_tgt_r;
        have_redir_s  = 1'b0;
        if (PCSrcE) begin
            redir_tgt_s  = aligned_tgt_s;
            have_redir_s = 1'b1;
        end else if (pend_r) begin
            redir_tgt_s  = pend_tgt_r;
            have_redir_s = 1'b1;
        end else begin
            redir_tgt_s  = pend_tgt_r;
            have_redir_s = 1'b0;
        end
    end

    // Sequential advance qualifier and the wrapping PC+4 adder.
    always_comb begin
        adv_s     = (state_r != BOOT) && ImemReady && !StallF;
        pcplus4_s = pcf_r + 32'd4;
    end

    // Fetch FSM: PC, pending redirect, request and misalignment registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= BOOT;
            pcf_r      <= RESET_VECTOR;
            pend_tgt_r <= 32'h0000_0000;
            pend_r     <= 1'b0;
            misalign_r <= 1'b0;
            imem_req_r <= 1'b0;
        end else begin
            // Pulse for exactly the cycle after a misaligned target is seen.
            misalign_r <= PCSrcE && (PCTargetE[1:0] != 2'b00);
            case (state_r)
                BOOT: begin
                    // No fetch yet; a redirect arriving now waits in the pending slot.
                    state_r    <= FETCH;
                    imem_req_r <= 1'b1;
                    if (PCSrcE) begin
                        pend_tgt_r <= aligned_tgt_s;
                        pend_r     <= 1'b1;
                    end else begin
                        pend_tgt_r <= pend_tgt_r;
                        pend_r     <= pend_r;
                    end
                end
                FETCH, HOLD: begin
                    imem_req_r <= 1'b1;
                    if (ImemReady && have_redir_s) begin
                        // Redirect wins over stall and over sequential advance.
                        pcf_r   <= redir_tgt_s;
                        pend_r  <= 1'b0;
                        state_r <= FETCH;
                    end else if (PCSrcE) begin
                        // Memory busy: remember the newest target and hold.
                        pend_tgt_r <= aligned_tgt_s;
                        pend_r     <= 1'b1;
                        state_r    <= HOLD;
                    end else if (adv_s) begin
                        pcf_r   <= pcplus4_s;
                        state_r <= FETCH;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r    <= BOOT;
                    pcf_r      <= RESET_VECTOR;
                    pend_r     <= 1'b0;
                    imem_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign PCF          = pcf_r;
    assign PCPlus4F     = pcplus4_s;
    assign ImemReq      = imem_req_r;
    assign RedirPending = pend_r;
    assign MisalignF    = misalign_r;
    // Flushes follow the resolved branch with no qualification.
    assign FlushD       = PCSrcE;
    assign FlushE       = PCSrcE;

endmodule
